fp8_unpack_pipe: RTL and testbench

Parametrised, two-stage pipelined FP8 unpacker for the CIM datapath. It accepts a vector of LANES packed FP8 operands in either E5M2 or OCP E4M3 format, selected per transfer. For each lane it produces the sign, the unbiased signed exponent, a 4-bit significand with the explicit hidden bit, and class flags. It sits between the operand fetch buffer and the CIM multiply array, and uses valid/ready handshakes on both sides.

---
 rtl/fp8_unpack_if.sv | 40 ++++
 rtl/fp8_unpack_pipe.sv | 197 +++++++++++++++++++
 tb/tb_fp8_unpack_pipe.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp8_unpack_if.sv
// ---------------------------------------------------------------------------
// fp8_unpack_if
// Purpose : bundles the input and output valid/ready channels of the FP8
//           unpacker so that the source and the sink share one handle.
// Signals : in_valid/in_ready/in_fmt/in_data   - packed operand beat
//           out_valid/out_ready                - decoded beat handshake
//           out_sign/out_exp/out_mant          - per-lane decoded fields
//           out_zero/out_inf/out_nan/out_fmt   - per-lane class, beat format
// Modports: master - the testbench / fetch side that drives the operands and
//           accepts the results; slave - the unpacker itself.
// ---------------------------------------------------------------------------
interface fp8_unpack_if #(
  parameter int LANES = 36
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_fmt;
  logic [LANES*8-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES-1:0]     out_sign;
  logic [LANES*6-1:0]   out_exp;
  logic [LANES*4-1:0]   out_mant;
  logic [LANES-1:0]     out_zero;
  logic [LANES-1:0]     out_inf;
  logic [LANES-1:0]     out_nan;
  logic                 out_fmt;

  modport master (
    output in_valid, in_fmt, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant,
           out_zero, out_inf, out_nan, out_fmt
  );

  modport slave (
    input  in_valid, in_fmt, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant,
           out_zero, out_inf, out_nan, out_fmt
  );
endinterface

// File: rtl/fp8_unpack_pipe.sv
// ---------------------------------------------------------------------------
// fp8_unpack_pipe
// Purpose : two-stage pipelined unpacker for LANES packed FP8 operands
//           (E5M2 or OCP E4M3, chosen per beat). Stage 1 registers the raw
//           beat, stage 2 registers the decoded sign / unbiased exponent /
//           4-bit significand with hidden bit / class flags.
// Ports   : clk, rst_n (async, active low)
//           bus  - fp8_unpack_if.slave, input and output valid/ready channels
//           stats_clr, out_nan_cnt - only when FP8_UNPACK_STATS_EN is defined:
//           synchronous clear and saturating count of NaN lanes transferred.
// Config  : define FP8_UNPACK_STATS_EN to add the NaN-lane statistics counter.
// ---------------------------------------------------------------------------
module fp8_unpack_pipe #(
  parameter int LANES = 36
) (
  input  logic           clk,
  input  logic           rst_n,
  fp8_unpack_if.slave    bus
`ifdef FP8_UNPACK_STATS_EN
  ,
  input  logic           stats_clr,
  output logic [15:0]    out_nan_cnt
`endif
);

  typedef struct packed {
    logic       sign;
    logic [5:0] exp;
    logic [3:0] mant;
    logic       zero;
    logic       inf;
    logic       nan;
  } lane_t;

  // Decode one FP8 byte; fmt 0 = E5M2 (bias 15), 1 = E4M3 (bias 7).
  // Specials and zero leave exp/mant at 0 and keep the sign.
  function automatic lane_t decode_lane(input logic [7:0] b, input logic fmt);
    lane_t r;
    r      = '0;
    r.sign = b[7];
    if (fmt == 1'b0) begin
      if (b[6:0] == 7'd0) begin
        r.zero = 1'b1;
      end else if (b[6:2] == 5'd31) begin
        if (b[1:0] == 2'd0) begin
          r.inf = 1'b1;
        end else begin
          r.nan = 1'b1;
        end
      end else if (b[6:2] == 5'd0) begin
        r.exp  = 6'h32;                       // -14
        r.mant = {1'b0, b[1:0], 1'b0};
      end else begin
        r.exp  = {1'b0, b[6:2]} - 6'd15;
        r.mant = {1'b1, b[1:0], 1'b0};
      end
    end else begin
      // E4M3 has no infinity; only S.1111.111 is NaN.
      if (b[6:0] == 7'h7F) begin
        r.nan = 1'b1;
      end else if (b[6:0] == 7'd0) begin
        r.zero = 1'b1;
      end else if (b[6:3] == 4'd0) begin
        r.exp  = 6'h3A;                       // -6
        r.mant = {1'b0, b[2:0]};
      end else begin
        r.exp  = {2'b00, b[6:3]} - 6'd7;
        r.mant = {1'b1, b[2:0]};
      end
    end
    return r;
  endfunction

  logic                 v1_r;
  logic [LANES*8-1:0]   d1_r;
  logic                 f1_r;
  logic                 v2_r;
  logic                 ready2_s;
  logic                 in_ready_s;
  lane_t                lane_s;
  logic [LANES-1:0]     sign_s;
  logic [LANES*6-1:0]   exp_s;
  logic [LANES*4-1:0]   mant_s;
  logic [LANES-1:0]     zero_s;
  logic [LANES-1:0]     inf_s;
  logic [LANES-1:0]     nan_s;
  logic [LANES-1:0]     sign_r;
  logic [LANES*6-1:0]   exp_r;
  logic [LANES*4-1:0]   mant_r;
  logic [LANES-1:0]     zero_r;
  logic [LANES-1:0]     inf_r;
  logic [LANES-1:0]     nan_r;
  logic                 fmt_r;

  // Each stage is free when empty or when its downstream takes the beat.
  assign ready2_s   = !v2_r || bus.out_ready;
  assign in_ready_s = !v1_r || ready2_s;
  assign bus.in_ready = in_ready_s;

  // Stage 1: capture the raw beat and its format on an accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      d1_r <= '0;
      f1_r <= 1'b0;
    end else if (in_ready_s) begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        d1_r <= bus.in_data;
        f1_r <= bus.in_fmt;
      end
    end
  end

  // Per-lane combinational decode of the stage-1 beat.
  always_comb begin
    lane_s = '0;
    sign_s = '0;
    exp_s  = '0;
    mant_s = '0;
    zero_s = '0;
    inf_s  = '0;
    nan_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_s           = decode_lane(d1_r[8*i +: 8], f1_r);
      sign_s[i]        = lane_s.sign;
      exp_s[6*i +: 6]  = lane_s.exp;
      mant_s[4*i +: 4] = lane_s.mant;
      zero_s[i]        = lane_s.zero;
      inf_s[i]         = lane_s.inf;
      nan_s[i]         = lane_s.nan;
    end
  end

  // Stage 2: register the decoded fields; holds while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      sign_r <= '0;
      exp_r  <= '0;
      mant_r <= '0;
      zero_r <= '0;
      inf_r  <= '0;
      nan_r  <= '0;
      fmt_r  <= 1'b0;
    end else if (ready2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        sign_r <= sign_s;
        exp_r  <= exp_s;
        mant_r <= mant_s;
        zero_r <= zero_s;
        inf_r  <= inf_s;
        nan_r  <= nan_s;
        fmt_r  <= f1_r;
      end
    end
  end

  assign bus.out_valid = v2_r;
  assign bus.out_sign  = sign_r;
  assign bus.out_exp   = exp_r;
  assign bus.out_mant  = mant_r;
  assign bus.out_zero  = zero_r;
  assign bus.out_inf   = inf_r;
  assign bus.out_nan   = nan_r;
  assign bus.out_fmt   = fmt_r;

`ifdef FP8_UNPACK_STATS_EN
  function automatic logic [6:0] popcount(input logic [LANES-1:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  logic [15:0] nan_cnt_r;
  logic [16:0] nan_sum_s;

  assign nan_sum_s   = {1'b0, nan_cnt_r} + {10'd0, popcount(nan_r)};
  assign out_nan_cnt = nan_cnt_r;

  // NaN-lane counter: clear wins, otherwise accumulate on transfer, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_cnt_r <= 16'd0;
    end else if (stats_clr) begin
      nan_cnt_r <= 16'd0;
    end else if (v2_r && bus.out_ready) begin
      nan_cnt_r <= nan_sum_s[16] ? 16'hFFFF : nan_sum_s[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fp8_unpack_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp8_unpack_pipe
// Purpose : self-checking bench for fp8_unpack_pipe. Directed beats from the
//           test plan plus randomized traffic with random back-pressure, all
//           checked against an integer-arithmetic reference and a scoreboard.
// Config  : define FP8_UNPACK_STATS_EN to also exercise the NaN counter.
// ---------------------------------------------------------------------------
module tb_fp8_unpack_pipe;
  localparam int LANES = 36;
  localparam int W     = LANES * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp8_unpack_if #(.LANES(LANES)) bus();

`ifdef FP8_UNPACK_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] out_nan_cnt;
`endif

  fp8_unpack_pipe #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FP8_UNPACK_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .out_nan_cnt (out_nan_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic rand_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] data;
    logic         fmt;
  } beat_t;
  beat_t sbq[$];

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: value semantics of one FP8 byte in plain integers.
  function automatic void ref_lane(input logic [7:0] b, input logic fmt,
                                   output logic s, output int ex, output int mt,
                                   output logic z, output logic inf, output logic nan);
    int e, m;
    s = b[7]; z = 1'b0; inf = 1'b0; nan = 1'b0; ex = 0; mt = 0;
    if (!fmt) begin
      e = int'(b[6:2]); m = int'(b[1:0]);
      if (e == 0 && m == 0)      z = 1'b1;
      else if (e == 31)          begin if (m == 0) inf = 1'b1; else nan = 1'b1; end
      else if (e == 0)           begin ex = 1 - 15; mt = m * 2; end
      else                       begin ex = e - 15; mt = 8 + m * 2; end
    end else begin
      e = int'(b[6:3]); m = int'(b[2:0]);
      if (e == 15 && m == 7)     nan = 1'b1;
      else if (e == 0 && m == 0) z = 1'b1;
      else if (e == 0)           begin ex = 1 - 7; mt = m; end
      else                       begin ex = e - 7; mt = 8 + m; end
    end
  endfunction

  function automatic void ref_beat(input logic [W-1:0] d, input logic fmt,
                                   output logic [LANES-1:0] es, output logic [LANES*6-1:0] ee,
                                   output logic [LANES*4-1:0] em, output logic [LANES-1:0] ez,
                                   output logic [LANES-1:0] ei, output logic [LANES-1:0] en);
    logic s, z, i1, n1;
    int ex, mt;
    for (int k = 0; k < LANES; k++) begin
      ref_lane(d[8*k +: 8], fmt, s, ex, mt, z, i1, n1);
      es[k] = s; ez[k] = z; ei[k] = i1; en[k] = n1;
      ee[6*k +: 6] = ex[5:0];
      em[4*k +: 4] = mt[3:0];
    end
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the update edge.
  int nan_model = 0;
  always @(negedge clk) begin : mon
    beat_t mb;
    logic [LANES-1:0]   es, ez, ei, en;
    logic [LANES*6-1:0] ee;
    logic [LANES*4-1:0] em;
    logic               xfer;
    xfer = 1'b0;
    en   = '0;
    if (!rst_n) begin
      nan_model = 0;
    end else begin
`ifdef FP8_UNPACK_STATS_EN
      check("nan_cnt", out_nan_cnt, nan_model[15:0]);
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_beat", bus.out_valid, 1'b0);
        end else begin
          mb = sbq.pop_front();
          ref_beat(mb.data, mb.fmt, es, ee, em, ez, ei, en);
          xfer = 1'b1;
          check("sign", bus.out_sign, es);
          check("exp",  bus.out_exp,  ee);
          check("mant", bus.out_mant, em);
          check("zero", bus.out_zero, ez);
          check("inf",  bus.out_inf,  ei);
          check("nan",  bus.out_nan,  en);
          check("fmt",  bus.out_fmt,  mb.fmt);
        end
      end
`ifdef FP8_UNPACK_STATS_EN
      if (stats_clr) nan_model = 0;
      else if (xfer) begin
        nan_model = nan_model + $countones(en);
        if (nan_model > 65535) nan_model = 65535;
      end
`endif
    end
  end

  // Random sink back-pressure.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [W-1:0] d, input logic f);
    int g;
    g = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_fmt = f;
    @(negedge clk);
    while (!bus.in_ready && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1'b1);
    else sbq.push_back('{d, f});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe with out_ready high; returns at the
  // falling edge where the beat is presented on the output.
  task automatic directed(input logic [W-1:0] d, input logic f);
    send(d, f);
    @(negedge clk);
    check("latency_early", bus.out_valid, 1'b0);
    @(negedge clk);
    check("latency", bus.out_valid, 1'b1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 2000) begin
      g++;
      @(negedge clk);
    end
    check("drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] fill(input logic [7:0] b);
    logic [W-1:0] d;
    for (int k = 0; k < LANES; k++) d[8*k +: 8] = b;
    return d;
  endfunction

  logic [W-1:0] d;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_fmt = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_exp",   bus.out_exp,   '0);
    check("rst_out_flags", {bus.out_sign, bus.out_zero, bus.out_inf, bus.out_nan, bus.out_fmt}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // E5M2 1.0 in every lane, then -inf.
    directed(fill(8'h3C), 1'b0);
    check("one_sign", bus.out_sign, '0);
    check("one_exp",  bus.out_exp,  '0);
    check("one_mant", bus.out_mant, {LANES{4'b1000}});
    check("one_flags", {bus.out_zero, bus.out_inf, bus.out_nan}, '0);
    drain();
    directed(fill(8'hFC), 1'b0);
    check("ninf_sign", bus.out_sign, {LANES{1'b1}});
    check("ninf_inf",  bus.out_inf,  {LANES{1'b1}});
    check("ninf_mant", bus.out_mant, '0);
    drain();

    // E4M3 mixed lanes.
    d = '0; d[7:0] = 8'h38; d[15:8] = 8'h7F; d[23:16] = 8'h01; d[31:24] = 8'h80;
    directed(d, 1'b1);
    check("e4_l0_exp",  bus.out_exp[5:0],   6'h00);
    check("e4_l0_mant", bus.out_mant[3:0],  4'b1000);
    check("e4_l1_nan",  bus.out_nan[1],     1'b1);
    check("e4_l2_exp",  bus.out_exp[17:12], 6'h3A);
    check("e4_l2_mant", bus.out_mant[11:8], 4'b0001);
    check("e4_l3_zero", bus.out_zero[3],    1'b1);
    check("e4_l3_sign", bus.out_sign[3],    1'b1);
    drain();

    // E5M2 subnormal, NaN, max normal.
    d = '0; d[7:0] = 8'h01; d[15:8] = 8'h7D; d[23:16] = 8'h7B;
    directed(d, 1'b0);
    check("e5_l0_exp",  bus.out_exp[5:0],   6'h32);
    check("e5_l0_mant", bus.out_mant[3:0],  4'b0010);
    check("e5_l1_nan",  bus.out_nan[1],     1'b1);
    check("e5_l2_exp",  bus.out_exp[17:12], 6'd15);
    check("e5_l2_mant", bus.out_mant[11:8], 4'b1110);
    drain();

    // Same byte, alternating format.
    directed(fill(8'h7E), 1'b0);
    check("alt_e5_nan", bus.out_nan, {LANES{1'b1}});
    drain();
    directed(fill(8'h7E), 1'b1);
    check("alt_e4_exp",  bus.out_exp,  {LANES{6'd8}});
    check("alt_e4_mant", bus.out_mant, {LANES{4'b1110}});
    drain();
    for (int k = 0; k < 6; k++) send(fill(8'h7E), k[0]);
    drain();

    // Back-pressure: sink stalled 5 cycles while 4 beats are offered.
    bus.out_ready = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        send(fill(8'h11), 1'b0);
        send(fill(8'h22), 1'b1);
        bus.in_valid = 1'b1; bus.in_data = fill(8'h33); bus.in_fmt = 1'b0;
        @(negedge clk);
        check("bp_in_ready_low", bus.in_ready, 1'b0);
        check("bp_out_valid", bus.out_valid, 1'b1);
        send(fill(8'h33), 1'b0);
        send(fill(8'h44), 1'b1);
      end
    join
    drain();

    // Randomized traffic with random sink stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < LANES; k++) d[8*k +: 8] = 8'($urandom);
      send(d, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain();

`ifdef FP8_UNPACK_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    @(negedge clk);
    check("stats_clr", out_nan_cnt, 16'd0);
    @(posedge clk); #1;
    d = '0;
    for (int k = 0; k < 5; k++) d[8*k +: 8] = 8'h7F;
    for (int n = 0; n < 3; n++) send(d, 1'b1);
    drain();
    check("stats_15", out_nan_cnt, 16'd15);
    for (int n = 0; n < 1822; n++) send(fill(8'h7F), 1'b1);
    drain();
    check("stats_sat", out_nan_cnt, 16'hFFFF);
`endif

    // Reset while two beats are buffered.
    bus.out_ready = 1'b0;
    send(fill(8'h3C), 1'b0);
    send(fill(8'h7F), 1'b1);
    @(negedge clk);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sbq.delete();
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_data", {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_nan}, '0);
`ifdef FP8_UNPACK_STATS_EN
    check("mid_rst_cnt", out_nan_cnt, 16'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    directed(fill(8'h40), 1'b1);
    check("post_rst_exp", bus.out_exp, {LANES{6'd1}});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
